// File: rtl/if_queue_if.sv
// Fetch-to-decode instruction queue bus: two-wide fetch enqueue side and
// two-wide decode dequeue side, plus occupancy.
interface if_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid_a;
  logic [31:0]   in_pc_a;
  logic [31:0]   in_instr_a;
  logic          in_valid_b;
  logic [31:0]   in_pc_b;
  logic [31:0]   in_instr_b;
  logic          in_ready;
  logic [1:0]    deq_cnt;
  logic          out_valid_a;
  logic [31:0]   out_pc_a;
  logic [31:0]   out_instr_a;
  logic          out_valid_b;
  logic [31:0]   out_pc_b;
  logic [31:0]   out_instr_b;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid_a, in_pc_a, in_instr_a,
    input  in_valid_b, in_pc_b, in_instr_b,
    input  deq_cnt,
    output in_ready,
    output out_valid_a, out_pc_a, out_instr_a,
    output out_valid_b, out_pc_b, out_instr_b,
    output count
  );

  modport master (
    output in_valid_a, in_pc_a, in_instr_a,
    output in_valid_b, in_pc_b, in_instr_b,
    output deq_cnt,
    input  in_ready,
    input  out_valid_a, out_pc_a, out_instr_a,
    input  out_valid_b, out_pc_b, out_instr_b,
    input  count
  );
endinterface

// File: rtl/if_queue.sv
// Two-in / two-out circular instruction queue between fetch and decode.
// Flush clears pointers on a branch redirect; storage itself is never reset.
module if_queue #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  if_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready, enq_a, enq_b;
  logic [1:0]    enq_n, deq_n;

  // Readiness looks only at registered occupancy; no credit for same-cycle dequeue.
  assign in_ready = (count_q <= CW'(DEPTH - 2)) && !flush;
  assign enq_a    = in_ready && bus.in_valid_a;
  assign enq_b    = enq_a && bus.in_valid_b;
  assign enq_n    = {1'b0, enq_a} + {1'b0, enq_b};
  assign head_p1  = head_q + PW'(1);
  assign tail_p1  = tail_q + PW'(1);

  always_comb begin
    deq_n = 2'd0;
    case (bus.deq_cnt)
      2'd1:    deq_n = (count_q != '0) ? 2'd1 : 2'd0;
      2'd2:    deq_n = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
      default: deq_n = 2'd0;
    endcase
  end

  always_comb begin
    head_d  = head_q + PW'(deq_n);
    tail_d  = tail_q + PW'(enq_n);
    count_d = count_q + CW'(enq_n) - CW'(deq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_a) begin
      pc_mem_q[tail_q]    <= bus.in_pc_a;
      instr_mem_q[tail_q] <= bus.in_instr_a;
    end
    if (enq_b) begin
      pc_mem_q[tail_p1]    <= bus.in_pc_b;
      instr_mem_q[tail_p1] <= bus.in_instr_b;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.count       = count_q;
  assign bus.out_valid_a = (count_q != '0);
  assign bus.out_valid_b = (count_q >= CW'(2));
  assign bus.out_pc_a    = bus.out_valid_a ? pc_mem_q[head_q]     : '0;
  assign bus.out_instr_a = bus.out_valid_a ? instr_mem_q[head_q]  : '0;
  assign bus.out_pc_b    = bus.out_valid_b ? pc_mem_q[head_p1]    : '0;
  assign bus.out_instr_b = bus.out_valid_b ? instr_mem_q[head_p1] : '0;
endmodule

// File: tb/tb_if_queue.sv
// Bench for if_queue: vector table with hand-computed expectations plus a
// scoreboard queue of fetched entries compared as decode consumes them.
module tb_if_queue;
  localparam int DEPTH = 8;

  typedef struct {
    logic        fl;
    logic        va;
    logic [31:0] pca;
    logic [31:0] ia;
    logic        vb;
    logic [31:0] pcb;
    logic [31:0] ib;
    logic [1:0]  deq;
    logic        rdy;
    int          cnt;
    logic [31:0] epa;
    logic [31:0] epb;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];
  vec_t tbl[34];

  if_queue_if #(.DEPTH(DEPTH)) bus();

  if_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mkv(input logic fl, input logic va, input logic [31:0] pca,
                               input logic vb, input logic [31:0] pcb, input logic [1:0] deq,
                               input logic rdy, input int cnt,
                               input logic [31:0] epa, input logic [31:0] epb);
    vec_t v;
    v.fl = fl; v.va = va; v.pca = pca; v.ia = mk(pca);
    v.vb = vb; v.pcb = pcb; v.ib = mk(pcb); v.deq = deq;
    v.rdy = rdy; v.cnt = cnt; v.epa = epa; v.epb = epb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] pa, ia, pb, ib;
    pa = (sb.size() >= 1) ? sb[0].pc    : 32'h0;
    ia = (sb.size() >= 1) ? sb[0].instr : 32'h0;
    pb = (sb.size() >= 2) ? sb[1].pc    : 32'h0;
    ib = (sb.size() >= 2) ? sb[1].instr : 32'h0;
    chk($sformatf("%s count_mdl", tag), 32'(bus.count), 32'(sb.size()));
    chk($sformatf("%s valid_a", tag), 32'(bus.out_valid_a), 32'(sb.size() >= 1));
    chk($sformatf("%s valid_b", tag), 32'(bus.out_valid_b), 32'(sb.size() >= 2));
    chk($sformatf("%s pc_a_mdl", tag), bus.out_pc_a, pa);
    chk($sformatf("%s instr_a", tag), bus.out_instr_a, ia);
    chk($sformatf("%s pc_b_mdl", tag), bus.out_pc_b, pb);
    chk($sformatf("%s instr_b", tag), bus.out_instr_b, ib);
  endtask

  task automatic step(input vec_t v, input int idx);
    int   dn;
    bit   mrdy;
    ent_t e;
    flush          = v.fl;
    bus.in_valid_a = v.va;
    bus.in_pc_a    = v.pca;
    bus.in_instr_a = v.ia;
    bus.in_valid_b = v.vb;
    bus.in_pc_b    = v.pcb;
    bus.in_instr_b = v.ib;
    bus.deq_cnt    = v.deq;
    #3;
    mrdy = ((DEPTH - sb.size()) >= 2) && !v.fl;
    chk($sformatf("v%0d ready_tbl", idx), 32'(bus.in_ready), 32'(v.rdy));
    chk($sformatf("v%0d ready_mdl", idx), 32'(bus.in_ready), 32'(mrdy));
    dn = (v.deq == 2'd3) ? 0 : ((int'(v.deq) > sb.size()) ? sb.size() : int'(v.deq));
    if (!v.fl) begin
      for (int i = 0; i < dn; i++) begin
        e = sb.pop_front();
        chk($sformatf("v%0d deq%0d pc", idx, i), (i == 0) ? bus.out_pc_a : bus.out_pc_b, e.pc);
        chk($sformatf("v%0d deq%0d instr", idx, i),
            (i == 0) ? bus.out_instr_a : bus.out_instr_b, e.instr);
      end
    end
    if (mrdy && v.va) begin
      sb.push_back('{pc: v.pca, instr: v.ia});
      if (v.vb) sb.push_back('{pc: v.pcb, instr: v.ib});
    end
    if (v.fl) sb.delete();
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 32'(bus.count), 32'(v.cnt));
    chk($sformatf("v%0d pc_a", idx), bus.out_pc_a, v.epa);
    chk($sformatf("v%0d pc_b", idx), bus.out_pc_b, v.epb);
    check_model($sformatf("v%0d", idx));
  endtask

  initial begin
    // fl va pca      vb pcb      deq rdy cnt epa      epb
    tbl[0]  = mkv(0, 1, 32'h00, 1, 32'h04, 2'd0, 1, 2, 32'h00, 32'h04);
    tbl[0].ia = 32'h0050_0093;
    tbl[0].ib = 32'h0030_0113;
    tbl[1]  = mkv(0, 1, 32'h08, 1, 32'h0C, 2'd0, 1, 4, 32'h00, 32'h04);
    tbl[2]  = mkv(0, 1, 32'h10, 1, 32'h14, 2'd0, 1, 6, 32'h00, 32'h04);
    tbl[3]  = mkv(0, 1, 32'h18, 1, 32'h1C, 2'd0, 1, 8, 32'h00, 32'h04);
    tbl[4]  = mkv(0, 1, 32'h20, 1, 32'h24, 2'd0, 0, 8, 32'h00, 32'h04);
    tbl[5]  = mkv(0, 0, 32'h00, 0, 32'h00, 2'd3, 0, 8, 32'h00, 32'h04);
    tbl[6]  = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 0, 6, 32'h08, 32'h0C);
    tbl[7]  = mkv(0, 1, 32'h20, 1, 32'h24, 2'd2, 1, 6, 32'h10, 32'h14);
    tbl[8]  = mkv(0, 1, 32'h28, 0, 32'h00, 2'd1, 1, 6, 32'h14, 32'h18);
    tbl[9]  = mkv(0, 0, 32'h00, 1, 32'h99, 2'd0, 1, 6, 32'h14, 32'h18);
    tbl[10] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 4, 32'h1C, 32'h20);
    tbl[11] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd3, 1, 4, 32'h1C, 32'h20);
    tbl[12] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 2, 32'h24, 32'h28);
    tbl[13] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd1, 1, 1, 32'h28, 32'h00);
    tbl[14] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 0, 32'h00, 32'h00);
    tbl[15] = mkv(0, 1, 32'h10, 1, 32'h14, 2'd0, 1, 2, 32'h10, 32'h14);
    tbl[16] = mkv(0, 1, 32'h18, 0, 32'h00, 2'd0, 1, 3, 32'h10, 32'h14);
    tbl[17] = mkv(0, 1, 32'h1C, 1, 32'h20, 2'd1, 1, 4, 32'h14, 32'h18);
    tbl[18] = mkv(0, 1, 32'h24, 0, 32'h00, 2'd0, 1, 5, 32'h14, 32'h18);
    tbl[19] = mkv(1, 1, 32'h28, 0, 32'h00, 2'd2, 0, 0, 32'h00, 32'h00);
    tbl[20] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd0, 1, 0, 32'h00, 32'h00);
    tbl[21] = mkv(0, 1, 32'h50, 1, 32'h54, 2'd0, 1, 2, 32'h50, 32'h54);
    tbl[22] = mkv(0, 1, 32'h58, 1, 32'h5C, 2'd2, 1, 2, 32'h58, 32'h5C);
    tbl[23] = mkv(0, 1, 32'h60, 1, 32'h64, 2'd2, 1, 2, 32'h60, 32'h64);
    tbl[24] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 0, 32'h00, 32'h00);
    tbl[25] = mkv(0, 1, 32'h40, 1, 32'h44, 2'd0, 1, 2, 32'h40, 32'h44);
    tbl[26] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 0, 32'h00, 32'h00);
    tbl[27] = mkv(0, 1, 32'h70, 0, 32'h00, 2'd0, 1, 1, 32'h70, 32'h00);
    tbl[28] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd1, 1, 0, 32'h00, 32'h00);
    tbl[29] = mkv(0, 1, 32'h80, 1, 32'h84, 2'd0, 1, 2, 32'h80, 32'h84);
    tbl[30] = mkv(0, 1, 32'h88, 1, 32'h8C, 2'd2, 1, 2, 32'h88, 32'h8C);
    tbl[31] = mkv(0, 1, 32'h90, 1, 32'h94, 2'd2, 1, 2, 32'h90, 32'h94);
    tbl[32] = mkv(0, 1, 32'h98, 1, 32'h9C, 2'd2, 1, 2, 32'h98, 32'h9C);
    tbl[33] = mkv(0, 0, 32'h00, 0, 32'h00, 2'd2, 1, 0, 32'h00, 32'h00);

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid_a = 1'b0; bus.in_pc_a = '0; bus.in_instr_a = '0;
    bus.in_valid_b = 1'b0; bus.in_pc_b = '0; bus.in_instr_b = '0;
    bus.deq_cnt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst count", 32'(bus.count), 32'h0);
    chk("rst valid_a", 32'(bus.out_valid_a), 32'h0);
    chk("rst valid_b", 32'(bus.out_valid_b), 32'h0);
    chk("rst pc_a", bus.out_pc_a, 32'h0);
    chk("rst instr_b", bus.out_instr_b, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 34; i++) step(tbl[i], i);

    // Reset mid-operation, colliding with flush and an enqueue.
    step(mkv(0, 1, 32'hA0, 1, 32'hA4, 2'd0, 1, 2, 32'hA0, 32'hA4), 100);
    step(mkv(0, 1, 32'hA8, 0, 32'h00, 2'd0, 1, 3, 32'hA0, 32'hA4), 101);
    rst = 1'b1;
    flush = 1'b1;
    bus.in_valid_a = 1'b1; bus.in_pc_a = 32'hB0; bus.in_instr_a = mk(32'hB0);
    bus.in_valid_b = 1'b1; bus.in_pc_b = 32'hB4; bus.in_instr_b = mk(32'hB4);
    bus.deq_cnt = 2'd1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("midrst count", 32'(bus.count), 32'h0);
    chk("midrst valid_a", 32'(bus.out_valid_a), 32'h0);
    chk("midrst pc_a", bus.out_pc_a, 32'h0);
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid_a = 1'b0;
    bus.in_valid_b = 1'b0;
    bus.deq_cnt = 2'd0;
    #1;
    chk("midrst in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check_model("post_rst");
    step(mkv(0, 1, 32'hC0, 1, 32'hC4, 2'd0, 1, 2, 32'hC0, 32'hC4), 102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
